// File: rtl/mem_lsu_pkg.sv
// Shared constants for the memory-access stage: bus widths, aluop codes,
// pipeline control levels and the LSU state encoding.
package mem_lsu_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;
  localparam int AluOpBus   = 8;

  localparam logic RstEnable = 1'b1;
  localparam logic Stop      = 1'b1;
  localparam logic NoStop    = 1'b0;

  localparam logic [RegAddrBus-1:0] NOPRegAddr = 5'b00000;

  localparam logic [AluOpBus-1:0] EXE_ADDU_OP = 8'b0010_0001;
  localparam logic [AluOpBus-1:0] EXE_LB_OP   = 8'b1110_0000;
  localparam logic [AluOpBus-1:0] EXE_LH_OP   = 8'b1110_0001;
  localparam logic [AluOpBus-1:0] EXE_LW_OP   = 8'b1110_0011;
  localparam logic [AluOpBus-1:0] EXE_LBU_OP  = 8'b1110_0100;
  localparam logic [AluOpBus-1:0] EXE_LHU_OP  = 8'b1110_0101;
  localparam logic [AluOpBus-1:0] EXE_SB_OP   = 8'b1110_1000;
  localparam logic [AluOpBus-1:0] EXE_SH_OP   = 8'b1110_1001;
  localparam logic [AluOpBus-1:0] EXE_SW_OP   = 8'b1110_1011;

  typedef enum logic [1:0] {
    LsuIdle = 2'd0,
    LsuBusy = 2'd1,
    LsuDone = 2'd2
  } lsu_state_e;

  // Big-endian byte lane: address offset 0 is the most significant byte.
  function automatic logic [3:0] byte_sel(input logic [1:0] addr_lo);
    return 4'b1000 >> addr_lo;
  endfunction

endpackage

// File: rtl/mem_lsu_lane.sv
// Byte-lane formatter: byte enables, store replication, load extension and
// alignment fault for one aluop/address pair. Purely combinational.
module lsu_lane
  import mem_lsu_pkg::*;
(
  input  logic [AluOpBus-1:0] i_aluop,
  input  logic [1:0]          i_addr_lo,
  input  logic [RegBus-1:0]   i_reg2,
  input  logic [RegBus-1:0]   i_rdata,
  output logic                o_is_mem,
  output logic                o_is_load,
  output logic                o_is_store,
  output logic [3:0]          o_sel,
  output logic [RegBus-1:0]   o_wdata,
  output logic [RegBus-1:0]   o_load_data,
  output logic                o_misaligned
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (i_addr_lo)
      2'b00:   w_byte = i_rdata[31:24];
      2'b01:   w_byte = i_rdata[23:16];
      2'b10:   w_byte = i_rdata[15:8];
      default: w_byte = i_rdata[7:0];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[15:0] : i_rdata[31:16];
  end

  always_comb begin
    o_is_mem     = 1'b0;
    o_is_load    = 1'b0;
    o_is_store   = 1'b0;
    o_sel        = 4'b0000;
    o_wdata      = i_reg2;
    o_load_data  = i_rdata;
    o_misaligned = 1'b0;
    case (i_aluop)
      EXE_LB_OP, EXE_LBU_OP: begin
        o_is_mem    = 1'b1;
        o_is_load   = 1'b1;
        o_sel       = byte_sel(i_addr_lo);
        o_load_data = (i_aluop == EXE_LB_OP) ? {{24{w_byte[7]}}, w_byte}
                                             : {24'h000000, w_byte};
      end
      EXE_LH_OP, EXE_LHU_OP: begin
        o_is_mem     = 1'b1;
        o_is_load    = 1'b1;
        o_sel        = i_addr_lo[1] ? 4'b0011 : 4'b1100;
        o_misaligned = i_addr_lo[0];
        o_load_data  = (i_aluop == EXE_LH_OP) ? {{16{w_half[15]}}, w_half}
                                              : {16'h0000, w_half};
      end
      EXE_LW_OP: begin
        o_is_mem     = 1'b1;
        o_is_load    = 1'b1;
        o_sel        = 4'b1111;
        o_misaligned = |i_addr_lo;
      end
      EXE_SB_OP: begin
        o_is_mem   = 1'b1;
        o_is_store = 1'b1;
        o_sel      = byte_sel(i_addr_lo);
        o_wdata    = {4{i_reg2[7:0]}};
      end
      EXE_SH_OP: begin
        o_is_mem     = 1'b1;
        o_is_store   = 1'b1;
        o_sel        = i_addr_lo[1] ? 4'b0011 : 4'b1100;
        o_misaligned = i_addr_lo[0];
        o_wdata      = {2{i_reg2[15:0]}};
      end
      EXE_SW_OP: begin
        o_is_mem     = 1'b1;
        o_is_store   = 1'b1;
        o_sel        = 4'b1111;
        o_misaligned = |i_addr_lo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM stage: runs loads/stores over a req/ack bus with an IDLE/BUSY/DONE FSM,
// holding the pipeline via stallreq; non-memory ops pass straight through.
module mem_lsu
  import mem_lsu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            stall,
  input  logic [RegAddrBus-1:0] mem_wd,
  input  logic                  mem_wreg,
  input  logic [RegBus-1:0]     mem_wdata,
  input  logic [RegBus-1:0]     mem_hi,
  input  logic [RegBus-1:0]     mem_lo,
  input  logic                  mem_whilo,
  input  logic [AluOpBus-1:0]   mem_aluop,
  input  logic [RegBus-1:0]     mem_mem_addr,
  input  logic [RegBus-1:0]     mem_reg2,
  input  logic                  mem_cp0_reg_we,
  input  logic [4:0]            mem_cp0_reg_write_addr,
  input  logic [RegBus-1:0]     mem_cp0_reg_data,
  input  logic [RegBus-1:0]     bus_rdata,
  input  logic                  bus_ack,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [RegBus-1:0]     bus_addr,
  output logic [3:0]            bus_sel,
  output logic [RegBus-1:0]     bus_wdata,
  output logic [RegAddrBus-1:0] wb_wd,
  output logic                  wb_wreg,
  output logic [RegBus-1:0]     wb_wdata,
  output logic [RegBus-1:0]     wb_hi,
  output logic [RegBus-1:0]     wb_lo,
  output logic                  wb_whilo,
  output logic                  wb_cp0_reg_we,
  output logic [4:0]            wb_cp0_reg_write_addr,
  output logic [RegBus-1:0]     wb_cp0_reg_data,
  output logic                  stallreq,
  output logic                  misaligned,
  output lsu_state_e            o_dbg_state
);

  // Bus handshake: bus_req stays high with stable addr/sel/we/wdata until
  // the cycle bus_ack=1; that cycle completes the access. bus_ack while
  // bus_req=0 carries no meaning and is ignored.

  lsu_state_e        r_state;
  lsu_state_e        w_next;
  logic [RegBus-1:0] r_rdata_q;
  logic              w_req;

  logic              w_is_mem;
  logic              w_is_load;
  logic              w_is_store;
  logic [3:0]        w_sel;
  logic [RegBus-1:0] w_store_data;
  logic [RegBus-1:0] w_load_data;
  logic              w_misaligned;
  logic              w_unused;

  assign w_unused = ^{stall[5], stall[3:0]};

  lsu_lane u_lane (
    .i_aluop      (mem_aluop),
    .i_addr_lo    (mem_mem_addr[1:0]),
    .i_reg2       (mem_reg2),
    .i_rdata      (r_rdata_q),
    .o_is_mem     (w_is_mem),
    .o_is_load    (w_is_load),
    .o_is_store   (w_is_store),
    .o_sel        (w_sel),
    .o_wdata      (w_store_data),
    .o_load_data  (w_load_data),
    .o_misaligned (w_misaligned)
  );

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_state   <= LsuIdle;
      r_rdata_q <= '0;
    end else begin
      r_state <= w_next;
      if (w_req && bus_ack) r_rdata_q <= bus_rdata;
    end
  end

  always_comb begin
    w_next = r_state;
    w_req  = 1'b0;
    case (r_state)
      LsuIdle: begin
        if (w_is_mem && !w_misaligned) begin
          w_req  = 1'b1;
          w_next = bus_ack ? LsuDone : LsuBusy;
        end
      end
      LsuBusy: begin
        w_req = 1'b1;
        if (bus_ack) w_next = LsuDone;
      end
      LsuDone: begin
        if (stall[4] == NoStop) w_next = LsuIdle;
      end
      default: w_next = LsuIdle;
    endcase
  end

  always_comb begin
    bus_req               = 1'b0;
    bus_we                = 1'b0;
    bus_addr              = '0;
    bus_sel               = 4'b0000;
    bus_wdata             = '0;
    wb_wd                 = NOPRegAddr;
    wb_wreg               = 1'b0;
    wb_wdata              = '0;
    wb_hi                 = '0;
    wb_lo                 = '0;
    wb_whilo              = 1'b0;
    wb_cp0_reg_we         = 1'b0;
    wb_cp0_reg_write_addr = 5'b00000;
    wb_cp0_reg_data       = '0;
    stallreq              = 1'b0;
    misaligned            = 1'b0;
    o_dbg_state           = LsuIdle;
    if (rst != RstEnable) begin
      bus_req               = w_req;
      bus_we                = w_req & w_is_store;
      bus_addr              = {mem_mem_addr[31:2], 2'b00};
      bus_sel               = w_sel;
      bus_wdata             = w_store_data;
      wb_wd                 = mem_wd;
      wb_wreg               = mem_wreg & ~w_is_store & ~w_misaligned;
      wb_wdata              = (w_is_load && r_state == LsuDone) ? w_load_data : mem_wdata;
      wb_hi                 = mem_hi;
      wb_lo                 = mem_lo;
      wb_whilo              = mem_whilo & ~w_misaligned;
      wb_cp0_reg_we         = mem_cp0_reg_we;
      wb_cp0_reg_write_addr = mem_cp0_reg_write_addr;
      wb_cp0_reg_data       = mem_cp0_reg_data;
      stallreq              = w_req;
      misaligned            = w_misaligned;
      o_dbg_state           = r_state;
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: driver tasks queue expected bus beats and
// stage results; a negedge monitor pops and compares them.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata, mem_hi, mem_lo;
  logic        mem_whilo;
  logic [7:0]  mem_aluop;
  logic [31:0] mem_mem_addr, mem_reg2;
  logic        mem_cp0_reg_we;
  logic [4:0]  mem_cp0_reg_write_addr;
  logic [31:0] mem_cp0_reg_data;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_sel;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata, wb_hi, wb_lo;
  logic        wb_whilo;
  logic        wb_cp0_reg_we;
  logic [4:0]  wb_cp0_reg_write_addr;
  logic [31:0] wb_cp0_reg_data;
  logic        stallreq, misaligned;
  lsu_state_e  dbg_state;

  mem_lsu dut (
    .clk(clk), .rst(rst), .stall(stall),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
    .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
    .mem_cp0_reg_we(mem_cp0_reg_we), .mem_cp0_reg_write_addr(mem_cp0_reg_write_addr),
    .mem_cp0_reg_data(mem_cp0_reg_data),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_sel(bus_sel), .bus_wdata(bus_wdata),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_whilo(wb_whilo),
    .wb_cp0_reg_we(wb_cp0_reg_we), .wb_cp0_reg_write_addr(wb_cp0_reg_write_addr),
    .wb_cp0_reg_data(wb_cp0_reg_data),
    .stallreq(stallreq), .misaligned(misaligned), .o_dbg_state(dbg_state)
  );

  // Clock and reset timing: 10-unit period; inputs change 1 unit after posedge.
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        cp0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_data;
    logic        mis;
    logic [7:0]  stalls;
    logic [1:0]  state;
  } res_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic        chk_wdata;
    logic [31:0] wdata;
  } bus_t;

  res_t res_q[$];
  bus_t bus_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   run_stall = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    res_t r;
    bus_t b;
    if (rst) begin
      check32("rst_bus_req",  {31'b0, bus_req},  32'h0);
      check32("rst_stallreq", {31'b0, stallreq}, 32'h0);
      check32("rst_bus_sel",  {28'b0, bus_sel},  32'h0);
      check32("rst_wb_wreg",  {31'b0, wb_wreg},  32'h0);
      check32("rst_wb_wdata", wb_wdata,          32'h0);
      check32("rst_wb_wd",    {27'b0, wb_wd},    32'h0);
      check32("rst_cp0_we",   {31'b0, wb_cp0_reg_we}, 32'h0);
      run_stall = 0;
    end else if (stallreq) begin
      run_stall++;
      check32("req_with_stall", {31'b0, bus_req}, 32'h1);
      if (bus_q.size() == 0) begin
        check32("bus_q_underflow", 32'h1, 32'h0);
      end else begin
        b = bus_q.pop_front();
        check32("bus_we",   {31'b0, bus_we}, {31'b0, b.we});
        check32("bus_addr", bus_addr,        b.addr);
        check32("bus_sel",  {28'b0, bus_sel}, {28'b0, b.sel});
        if (b.chk_wdata) check32("bus_wdata", bus_wdata, b.wdata);
      end
    end else begin
      check32("no_req_without_stall", {31'b0, bus_req}, 32'h0);
      if (res_q.size() == 0) begin
        check32("res_q_underflow", 32'h1, 32'h0);
      end else begin
        r = res_q.pop_front();
        check32("wb_wd",       {27'b0, wb_wd},    {27'b0, r.wd});
        check32("wb_wreg",     {31'b0, wb_wreg},  {31'b0, r.wreg});
        check32("wb_wdata",    wb_wdata,          r.wdata);
        check32("wb_whilo",    {31'b0, wb_whilo}, {31'b0, r.whilo});
        check32("wb_hi",       wb_hi,             r.hi);
        check32("wb_lo",       wb_lo,             r.lo);
        check32("wb_cp0_we",   {31'b0, wb_cp0_reg_we}, {31'b0, r.cp0_we});
        check32("wb_cp0_addr", {27'b0, wb_cp0_reg_write_addr}, {27'b0, r.cp0_addr});
        check32("wb_cp0_data", wb_cp0_reg_data,   r.cp0_data);
        check32("misaligned",  {31'b0, misaligned}, {31'b0, r.mis});
        check32("stall_cycles", 32'(run_stall),   {24'b0, r.stalls});
        check32("fsm_state",   {30'b0, dbg_state}, {30'b0, r.state});
      end
      run_stall = 0;
    end
  end

  // Driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_res(input logic [31:0] wdata, input logic wreg, input logic whilo,
                          input logic mis, input int stalls, input lsu_state_e st);
    res_t r;
    r.wd       = mem_wd;
    r.wreg     = wreg;
    r.wdata    = wdata;
    r.whilo    = whilo;
    r.hi       = mem_hi;
    r.lo       = mem_lo;
    r.cp0_we   = mem_cp0_reg_we;
    r.cp0_addr = mem_cp0_reg_write_addr;
    r.cp0_data = mem_cp0_reg_data;
    r.mis      = mis;
    r.stalls   = 8'(stalls);
    r.state    = st;
    res_q.push_back(r);
  endtask

  task automatic set_pass_in(input logic [4:0] wd, input logic [31:0] wdata);
    mem_aluop              = EXE_ADDU_OP;
    mem_wd                 = wd;
    mem_wreg               = 1'b1;
    mem_wdata              = wdata;
    mem_hi                 = 32'hAAAA_0001;
    mem_lo                 = 32'h5555_0002;
    mem_whilo              = 1'b1;
    mem_mem_addr           = 32'h0000_0005;
    mem_reg2               = 32'h0000_0055;
    mem_cp0_reg_we         = 1'b1;
    mem_cp0_reg_write_addr = 5'd12;
    mem_cp0_reg_data       = 32'hC0C0_0C0C;
  endtask

  task automatic do_pass(input logic [4:0] wd, input logic [31:0] wdata);
    set_pass_in(wd, wdata);
    push_res(wdata, 1'b1, 1'b1, 1'b0, 0, LsuIdle);
    cyc();
  endtask

  task automatic set_mem_in(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2);
    mem_aluop              = op;
    mem_wd                 = 5'd7;
    mem_wreg               = 1'b1;
    mem_wdata              = addr;
    mem_hi                 = 32'h1111_2222;
    mem_lo                 = 32'h3333_4444;
    mem_whilo              = 1'b0;
    mem_mem_addr           = addr;
    mem_reg2               = reg2;
    mem_cp0_reg_we         = 1'b0;
    mem_cp0_reg_write_addr = 5'd0;
    mem_cp0_reg_data       = 32'h0;
  endtask

  task automatic do_mem(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                        input logic is_store, input int n, input logic [31:0] rdata, input int h,
                        input logic [3:0] exp_sel, input logic [31:0] exp_bus_wdata,
                        input logic [31:0] exp_wb_wdata, input logic exp_wreg);
    bus_t b;
    set_mem_in(op, addr, reg2);
    for (int k = 0; k <= n; k++) begin
      b.we        = is_store;
      b.addr      = {addr[31:2], 2'b00};
      b.sel       = exp_sel;
      b.chk_wdata = is_store;
      b.wdata     = exp_bus_wdata;
      bus_q.push_back(b);
      bus_ack   = (k == n);
      bus_rdata = (k == n) ? rdata : 32'h5A5A_5A5A;
      cyc();
    end
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
    for (int j = 0; j <= h; j++) begin
      stall[4] = (j < h) ? Stop : NoStop;
      push_res(exp_wb_wdata, exp_wreg, 1'b0, 1'b0, (j == 0) ? n + 1 : 0, LsuDone);
      cyc();
    end
    stall = 6'b0;
  endtask

  task automatic do_misaligned(input logic [7:0] op, input logic [31:0] addr);
    set_mem_in(op, addr, 32'hFFFF_FFFF);
    mem_whilo = 1'b1;
    push_res(addr, 1'b0, 1'b0, 1'b1, 0, LsuIdle);
    cyc();
  endtask

  initial begin
    bus_t b;
    rst       = 1'b1;
    stall     = 6'b0;
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
    set_pass_in(5'd1, 32'h0);
    repeat (2) cyc();
    rst = 1'b0;

    // op, addr, reg2, store, ack delay, rdata, hold, sel, bus wdata, wb_wdata, wreg
    do_pass(5'd3, 32'h1234_5678);
    do_mem(EXE_LB_OP,  32'h0000_0100, 32'h0,          1'b0, 2, 32'h80FF_0000, 0, 4'b1000, 32'h0,          32'hFFFF_FF80, 1'b1);
    do_mem(EXE_SH_OP,  32'h0000_0202, 32'hAAAA_BEEF,  1'b1, 0, 32'h0,         0, 4'b0011, 32'hBEEF_BEEF,  32'h0000_0202, 1'b0);
    do_misaligned(EXE_LW_OP, 32'h0000_0101);
    do_mem(EXE_LHU_OP, 32'h0000_0102, 32'h0,          1'b0, 1, 32'h0000_8001, 2, 4'b0011, 32'h0,          32'h0000_8001, 1'b1);
    do_mem(EXE_SB_OP,  32'h0000_0103, 32'h1234_56A5,  1'b1, 1, 32'h0,         0, 4'b0001, 32'hA5A5_A5A5,  32'h0000_0103, 1'b0);
    do_mem(EXE_LH_OP,  32'h0000_0100, 32'h0,          1'b0, 0, 32'h8001_7F00, 0, 4'b1100, 32'h0,          32'hFFFF_8001, 1'b1);
    do_mem(EXE_LBU_OP, 32'h0000_0102, 32'h0,          1'b0, 1, 32'h0000_F000, 0, 4'b0010, 32'h0,          32'h0000_00F0, 1'b1);
    do_mem(EXE_SW_OP,  32'h0000_0400, 32'hDEAD_BEEF,  1'b1, 3, 32'h0,         0, 4'b1111, 32'hDEAD_BEEF,  32'h0000_0400, 1'b0);
    do_misaligned(EXE_SH_OP, 32'h0000_0201);
    do_mem(EXE_LB_OP,  32'h0000_0103, 32'h0,          1'b0, 0, 32'h0000_007F, 0, 4'b0001, 32'h0,          32'h0000_007F, 1'b1);

    // Reset lands while the FSM waits in BUSY; the ack that follows is stale.
    set_mem_in(EXE_LW_OP, 32'h0000_0300, 32'h0);
    b.we = 1'b0; b.addr = 32'h0000_0300; b.sel = 4'b1111; b.chk_wdata = 1'b0; b.wdata = 32'h0;
    bus_q.push_back(b);
    cyc();
    rst = 1'b1;
    set_pass_in(5'd2, 32'h0000_0099);
    cyc();
    rst       = 1'b0;
    bus_ack   = 1'b1;
    bus_rdata = 32'h1234_5678;
    do_pass(5'd4, 32'h0000_0AAA);
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
    do_mem(EXE_LW_OP,  32'h0000_0304, 32'h0,          1'b0, 1, 32'hCAFE_F00D, 0, 4'b1111, 32'h0,          32'hCAFE_F00D, 1'b1);
    do_pass(5'd5, 32'h0BAD_F00D);

    check32("res_q_drained", 32'(res_q.size()), 32'h0);
    check32("bus_q_drained", 32'(bus_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
